multicycle_control: RTL and testbench

- Moore-style control FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified instruction/data memory port, and the register file.
- Replaces the single-cycle main/ALU decode pairing when the core is built multicycle.
- Drives the mux selects and write enables each cycle from the current state.
- Decodes the latched instruction opcode in DECODE.
- Stalls on a memory ready handshake.

---
 rtl/multicycle_control_if.sv | 31 +++
 rtl/multicycle_control.sv | 128 ++++++++++++
 tb/tb_multicycle_control.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle RV32I core.
// The master side is the control FSM; the slave side is the datapath.
interface multicycle_control_if;
   logic [6:0] op;
   logic       funct3_0;
   logic       EQ;
   logic       mem_ready;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUop;
   logic       RegWrite;
   logic       instr_done;
   logic       illegal_op;

   modport master (
      input  op, funct3_0, EQ, mem_ready,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUop, RegWrite, instr_done, illegal_op
   );

   modport slave (
      output op, funct3_0, EQ, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUop, RegWrite, instr_done, illegal_op
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing the shared multicycle RV32I datapath.
// Per-state controls are registered alongside the state; only handshake/flag qualifiers and reset are combinational.
module multicycle_control #(
   parameter int STATE_W = 4  // minimum 4
) (
   input  logic                clk,
   input  logic                rst,
   multicycle_control_if.master bus
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2
   } state_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef struct packed {
      logic       adr_src;
      logic       mem_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       pc_update;
      logic       branch;
      logic       fetch;          // IRWrite/PCUpdate follow mem_ready
      logic       decode;         // illegal-opcode detection window
      logic       done;
      logic       done_on_ready;  // instr_done qualified by mem_ready
   } ctrl_t;

   state_e state_q, state_d;
   ctrl_t  ctrl_q;

   function automatic ctrl_t ctrl_of(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.alu_src_b = 2'b10; c.result_src = 2'b10; c.fetch = 1'b1; end
         S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.decode = 1'b1; end
         S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; c.done = 1'b1; end
         S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; c.done_on_ready = 1'b1; end
         S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
         S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
         S_ALUWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
         S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; c.done = 1'b1; end
         S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
         S_JALR:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
         S_JALR2:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
         default:    c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR,
         S_EXECI,
         S_JAL,
         S_JALR2:    state_d = S_ALUWB;
         S_JALR:     state_d = S_JALR2;
         default:    state_d = S_FETCH;
      endcase
   end

   // NOTE: state and registered controls use <= so every flop samples pre-edge values together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= ctrl_of(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_of(state_d);
      end
   end

   logic active;
   logic op_legal;
   logic illegal;

   assign active   = ~rst;
   assign op_legal = (bus.op == OP_LOAD) || (bus.op == OP_STORE) || (bus.op == OP_R) ||
                     (bus.op == OP_I) || (bus.op == OP_BR) || (bus.op == OP_JAL) ||
                     (bus.op == OP_JALR);
   assign illegal  = active & ctrl_q.decode & ~op_legal;

   // Reset gates every enable and select in the same cycle it is asserted.
   assign bus.PCWrite    = active & (ctrl_q.pc_update | (ctrl_q.fetch & bus.mem_ready) |
                                     (ctrl_q.branch & (bus.EQ ^ bus.funct3_0)));
   assign bus.IRWrite    = active & ctrl_q.fetch & bus.mem_ready;
   assign bus.AdrSrc     = active & ctrl_q.adr_src;
   assign bus.MemWrite   = active & ctrl_q.mem_write;
   assign bus.RegWrite   = active & ctrl_q.reg_write;
   assign bus.ResultSrc  = active ? ctrl_q.result_src : 2'b00;
   assign bus.ALUSrcA    = active ? ctrl_q.alu_src_a : 2'b00;
   assign bus.ALUSrcB    = active ? ctrl_q.alu_src_b : 2'b00;
   assign bus.ALUop      = active ? ctrl_q.alu_op : 2'b00;
   assign bus.illegal_op = illegal;
   assign bus.instr_done = illegal |
                           (active & (ctrl_q.done | (ctrl_q.done_on_ready & bus.mem_ready)));

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each instruction expands into its expected per-cycle control script,
// checked every cycle, plus literal per-instruction latencies.
module tb_multicycle_control;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_control_if bus();

   multicycle_control #(.STATE_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [6:0]  op;
      logic        f3;
      logic        eq;
      logic [14:0] exp;
   } row_t;

   row_t rows[$];
   int   lat_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUop, RegWrite, instr_done, illegal_op}
   function automatic logic [14:0] ov(logic pcw, logic adr, logic memw, logic irw,
                                      logic [1:0] res, logic [1:0] asa, logic [1:0] asb,
                                      logic [1:0] aop, logic regw, logic done, logic ill);
      return {pcw, adr, memw, irw, res, asa, asb, aop, regw, done, ill};
   endfunction

   task automatic add(input logic r, input logic rdy, input logic [6:0] op,
                      input logic f3, input logic eq, input logic [14:0] exp);
      row_t t;
      t.rst = r; t.rdy = rdy; t.op = op; t.f3 = f3; t.eq = eq; t.exp = exp;
      rows.push_back(t);
   endtask

   // Expand one instruction into its cycle script: wf fetch stalls, wm memory stalls.
   task automatic push_instr(input logic [6:0] op, input logic f3, input logic eq,
                             input int wf, input int wm);
      logic legal;
      legal = op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67};
      for (int i = 0; i < wf; i++)
         add(0, 0, op, f3, eq, ov(0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0,0));
      add(0, 1, op, f3, eq, ov(1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 0,0,0));
      add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,!legal,!legal));
      case (op)
         7'h03: begin
            add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0));
            for (int i = 0; i < wm; i++)
               add(0, 0, op, f3, eq, ov(0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0));
            add(0, 1, op, f3, eq, ov(0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0));
            add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 1,1,0));
         end
         7'h23: begin
            add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0));
            for (int i = 0; i < wm; i++)
               add(0, 0, op, f3, eq, ov(0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0));
            add(0, 1, op, f3, eq, ov(0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 0,1,0));
         end
         7'h33, 7'h13: begin
            add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b00,2'b10,(op == 7'h13) ? 2'b01 : 2'b00,2'b10, 0,0,0));
            add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0));
         end
         7'h63:
            add(0, 1, op, f3, eq, ov(eq ^ f3,0,0,0, 2'b00,2'b10,2'b00,2'b01, 0,1,0));
         7'h6f: begin
            add(0, 1, op, f3, eq, ov(1,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,0,0));
            add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0));
         end
         7'h67: begin
            add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0));
            add(0, 1, op, f3, eq, ov(1,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,0,0));
            add(0, 1, op, f3, eq, ov(0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0));
         end
         default: ;
      endcase
   endtask

   initial begin
      int          cyc;
      int          dones;
      logic [14:0] act;

      // Program: reset, then a directed instruction mix.
      add(1, 0, 7'h33, 0, 0, '0);
      add(1, 1, 7'h33, 0, 0, '0);
      push_instr(7'h33, 0, 0, 0, 0);   // add
      push_instr(7'h03, 0, 0, 0, 2);   // lw, 2 stalls in MEMREAD
      push_instr(7'h23, 0, 0, 0, 3);   // sw, 3 stalls in MEMWRITE
      push_instr(7'h63, 0, 1, 0, 0);   // beq taken
      push_instr(7'h63, 1, 1, 0, 0);   // bne not taken
      push_instr(7'h67, 0, 0, 0, 0);   // jalr
      push_instr(7'h00, 0, 0, 0, 0);   // illegal
      push_instr(7'h13, 0, 0, 2, 0);   // addi, 2 fetch stalls
      push_instr(7'h6f, 0, 1, 0, 0);   // jal
      push_instr(7'h23, 0, 0, 0, 3);   // sw aborted by reset while still in MEMWRITE
      repeat (3) void'(rows.pop_back());
      add(1, 0, 7'h23, 0, 0, '0);
      push_instr(7'h33, 0, 0, 0, 0);   // add after reset
      push_instr(7'h63, 0, 0, 0, 0);   // beq not taken
      push_instr(7'h63, 1, 0, 0, 0);   // bne taken
      lat_q = '{4, 7, 7, 3, 3, 5, 2, 6, 4, 4, 3, 3};

      cyc   = 0;
      dones = 0;
      // NOTE: inputs are driven with blocking assignments on the falling edge, away from the DUT's sampling edge.
      foreach (rows[k]) begin
         @(negedge clk);
         rst           = rows[k].rst;
         bus.mem_ready = rows[k].rdy;
         bus.op        = rows[k].op;
         bus.funct3_0  = rows[k].f3;
         bus.EQ        = rows[k].eq;
         #2;
         act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUop, bus.RegWrite, bus.instr_done,
                bus.illegal_op};
         check($sformatf("row%0d ctrl", k), {17'd0, act}, {17'd0, rows[k].exp});
         if (rows[k].rst) begin
            cyc = 0;
         end else begin
            cyc++;
            if (bus.instr_done === 1'b1) begin
               dones++;
               if (lat_q.size() == 0) check($sformatf("row%0d extra_done", k), 32'd1, 32'd0);
               else check($sformatf("row%0d latency", k), cyc, lat_q.pop_front());
               cyc = 0;
            end
         end
      end
      check("done_count", dones, 32'd12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
